// File: rtl/sram_decode_scheduler_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sched_pkg : state/owner types and defaults for the decode-flow scheduler.
// Rev 1.0
// ----------------------------------------------------------------------------
package sched_pkg;

    typedef enum logic [2:0] {
        S_SCH_DISPLAY = 3'd0,
        S_SCH_UART    = 3'd1,
        S_SCH_GUARD   = 3'd2,
        S_SCH_M2      = 3'd3,
        S_SCH_M1      = 3'd4
    } sched_state_type;

    typedef enum logic [1:0] {
        OWN_VGA  = 2'd0,
        OWN_UART = 2'd1,
        OWN_M2   = 2'd2,
        OWN_M1   = 2'd3
    } owner_sel_type;

    localparam logic [25:0] DEF_UART_TIMEOUT = 26'd49999999;
    localparam int          DEF_GUARD_CYCLES = 3;
    localparam int          DEF_ADDR_W       = 18;

endpackage
`default_nettype wire

// File: rtl/sram_decode_scheduler_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sram_decode_scheduler_if : unit handshakes and SRAM bus around the scheduler.
// Rev 1.0
// ----------------------------------------------------------------------------
interface sram_decode_scheduler_if #(
    parameter int ADDR_W = 18
);
    logic              uart_rx_line;
    logic              skip_m2;
    logic [ADDR_W-1:0] uart_sram_address;
    logic [15:0]       uart_sram_write_data;
    logic              uart_sram_we_n;
    logic              uart_rx_initialize;
    logic              uart_rx_enable;
    logic              m2_start;
    logic              m2_done;
    logic [ADDR_W-1:0] m2_sram_address;
    logic [15:0]       m2_sram_write_data;
    logic              m2_sram_we_n;
    logic              m1_start;
    logic              m1_done;
    logic [ADDR_W-1:0] m1_sram_address;
    logic [15:0]       m1_sram_write_data;
    logic              m1_sram_we_n;
    logic [ADDR_W-1:0] vga_sram_address;
    logic              vga_enable;
    logic [ADDR_W-1:0] SRAM_address;
    logic [15:0]       SRAM_write_data;
    logic              SRAM_we_n;
    logic [2:0]        sched_state;
    logic              protocol_error;

    modport master (
        input  uart_rx_line, skip_m2,
        input  uart_sram_address, uart_sram_write_data, uart_sram_we_n,
        input  m2_done, m2_sram_address, m2_sram_write_data, m2_sram_we_n,
        input  m1_done, m1_sram_address, m1_sram_write_data, m1_sram_we_n,
        input  vga_sram_address,
        output uart_rx_initialize, uart_rx_enable, m2_start, m1_start, vga_enable,
        output SRAM_address, SRAM_write_data, SRAM_we_n, sched_state, protocol_error
    );

    modport slave (
        output uart_rx_line, skip_m2,
        output uart_sram_address, uart_sram_write_data, uart_sram_we_n,
        output m2_done, m2_sram_address, m2_sram_write_data, m2_sram_we_n,
        output m1_done, m1_sram_address, m1_sram_write_data, m1_sram_we_n,
        output vga_sram_address,
        input  uart_rx_initialize, uart_rx_enable, m2_start, m1_start, vga_enable,
        input  SRAM_address, SRAM_write_data, SRAM_we_n, sched_state, protocol_error
    );
endinterface
`default_nettype wire

// File: rtl/sram_decode_scheduler_owner_mux.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sram_owner_mux : 4-way SRAM port select with a forced-idle guard override.
// Rev 1.0
// ----------------------------------------------------------------------------
module sram_owner_mux
    import sched_pkg::*;
#(
    parameter int ADDR_W = 18
) (
    input  var owner_sel_type     owner_i,
    input  wire                   idle_i,
    input  wire [ADDR_W-1:0]      vga_addr_i,
    input  wire [ADDR_W-1:0]      uart_addr_i,
    input  wire [15:0]            uart_wdata_i,
    input  wire                   uart_we_n_i,
    input  wire [ADDR_W-1:0]      m2_addr_i,
    input  wire [15:0]            m2_wdata_i,
    input  wire                   m2_we_n_i,
    input  wire [ADDR_W-1:0]      m1_addr_i,
    input  wire [15:0]            m1_wdata_i,
    input  wire                   m1_we_n_i,
    output logic [ADDR_W-1:0]     sram_addr_o,
    output logic [15:0]           sram_wdata_o,
    output logic                  sram_we_n_o
);

    always_comb begin
        sram_addr_o  = vga_addr_i;
        sram_wdata_o = 16'd0;
        sram_we_n_o  = 1'b1;
        case (owner_i)
            OWN_UART: begin
                sram_addr_o  = uart_addr_i;
                sram_wdata_o = uart_wdata_i;
                sram_we_n_o  = uart_we_n_i;
            end
            OWN_M2: begin
                sram_addr_o  = m2_addr_i;
                sram_wdata_o = m2_wdata_i;
                sram_we_n_o  = m2_we_n_i;
            end
            OWN_M1: begin
                sram_addr_o  = m1_addr_i;
                sram_wdata_o = m1_wdata_i;
                sram_we_n_o  = m1_we_n_i;
            end
            default: ;
        endcase
        // Guard wins over any owner so in-flight reads drain undisturbed.
        if (idle_i) begin
            sram_addr_o  = '0;
            sram_wdata_o = 16'd0;
            sram_we_n_o  = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_decode_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sram_decode_scheduler : sequences UART load -> M2 -> M1 -> VGA and owns SRAM.
// Rev 1.0
// ----------------------------------------------------------------------------
module sram_decode_scheduler
    import sched_pkg::*;
#(
    parameter logic [25:0] UART_TIMEOUT = DEF_UART_TIMEOUT,
    parameter int          GUARD_CYCLES = DEF_GUARD_CYCLES,
    parameter int          ADDR_W       = DEF_ADDR_W
) (
    input wire Clock,
    input wire Resetn,
    sram_decode_scheduler_if.master bus
);

    localparam int            GW         = (GUARD_CYCLES > 2) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES - 1);

    sched_state_type state_q, state_d;
    sched_state_type target_q, target_d;
    logic [25:0]     timer_q, timer_d;
    logic [GW-1:0]   guard_cnt_q, guard_cnt_d;
    logic            init_q, init_d;
    logic            enable_q, enable_d;
    logic            m2_start_q, m2_start_d;
    logic            m1_start_q, m1_start_d;
    logic            vga_enable_q, vga_enable_d;
    logic            error_q, error_d;
    owner_sel_type   owner;
    logic            guard_idle;
    logic [ADDR_W-1:0] mux_addr;
    logic [15:0]     mux_wdata;
    logic            mux_we_n;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q      <= S_SCH_DISPLAY;
            target_q     <= S_SCH_DISPLAY;
            timer_q      <= 26'd0;
            guard_cnt_q  <= '0;
            init_q       <= 1'b0;
            enable_q     <= 1'b0;
            m2_start_q   <= 1'b0;
            m1_start_q   <= 1'b0;
            vga_enable_q <= 1'b1;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            timer_q      <= timer_d;
            guard_cnt_q  <= guard_cnt_d;
            init_q       <= init_d;
            enable_q     <= enable_d;
            m2_start_q   <= m2_start_d;
            m1_start_q   <= m1_start_d;
            vga_enable_q <= vga_enable_d;
            error_q      <= error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        timer_d     = timer_q;
        guard_cnt_d = guard_cnt_q;
        case (state_q)
            S_SCH_DISPLAY: begin
                if (!bus.uart_rx_line) begin
                    state_d = S_SCH_UART;
                    timer_d = 26'd0;
                end
            end
            S_SCH_UART: begin
                if (timer_q == UART_TIMEOUT) begin
                    state_d     = S_SCH_GUARD;
                    target_d    = bus.skip_m2 ? S_SCH_M1 : S_SCH_M2;
                    guard_cnt_d = GUARD_LOAD;
                end else if (!bus.uart_sram_we_n) begin
                    timer_d = 26'd0;
                end else begin
                    timer_d = timer_q + 26'd1;
                end
            end
            S_SCH_GUARD: begin
                if (guard_cnt_q == '0) state_d = target_q;
                else                   guard_cnt_d = guard_cnt_q - 1'b1;
            end
            S_SCH_M2: begin
                if (bus.m2_done) begin
                    state_d     = S_SCH_GUARD;
                    target_d    = S_SCH_M1;
                    guard_cnt_d = GUARD_LOAD;
                end
            end
            S_SCH_M1: begin
                if (bus.m1_done) begin
                    state_d     = S_SCH_GUARD;
                    target_d    = S_SCH_DISPLAY;
                    guard_cnt_d = GUARD_LOAD;
                end
            end
            default: state_d = S_SCH_DISPLAY;
        endcase
    end

    always_comb begin
        init_d       = 1'b0;
        enable_d     = init_q;
        m2_start_d   = 1'b0;
        m1_start_d   = 1'b0;
        vga_enable_d = vga_enable_q;
        owner        = OWN_VGA;
        guard_idle   = 1'b0;
        case (state_q)
            S_SCH_DISPLAY: begin
                if (!bus.uart_rx_line) begin
                    init_d       = 1'b1;
                    vga_enable_d = 1'b0;
                end
            end
            S_SCH_UART: owner = OWN_UART;
            S_SCH_GUARD: begin
                guard_idle = 1'b1;
                if (guard_cnt_q == '0) begin
                    m2_start_d = (target_q == S_SCH_M2);
                    m1_start_d = (target_q == S_SCH_M1);
                    if (target_q == S_SCH_DISPLAY) vga_enable_d = 1'b1;
                end
            end
            S_SCH_M2: owner = OWN_M2;
            S_SCH_M1: owner = OWN_M1;
            default: ;
        endcase
        // A misdirected done pulse only flags the error; the FSM ignores it.
        error_d = error_q
                | (!bus.uart_sram_we_n && state_q != S_SCH_UART)
                | (!bus.m2_sram_we_n   && state_q != S_SCH_M2)
                | (!bus.m1_sram_we_n   && state_q != S_SCH_M1)
                | (bus.m2_done         && state_q != S_SCH_M2)
                | (bus.m1_done         && state_q != S_SCH_M1);
    end

    sram_owner_mux #(
        .ADDR_W (ADDR_W)
    ) u_owner_mux (
        .owner_i      (owner),
        .idle_i       (guard_idle),
        .vga_addr_i   (bus.vga_sram_address),
        .uart_addr_i  (bus.uart_sram_address),
        .uart_wdata_i (bus.uart_sram_write_data),
        .uart_we_n_i  (bus.uart_sram_we_n),
        .m2_addr_i    (bus.m2_sram_address),
        .m2_wdata_i   (bus.m2_sram_write_data),
        .m2_we_n_i    (bus.m2_sram_we_n),
        .m1_addr_i    (bus.m1_sram_address),
        .m1_wdata_i   (bus.m1_sram_write_data),
        .m1_we_n_i    (bus.m1_sram_we_n),
        .sram_addr_o  (mux_addr),
        .sram_wdata_o (mux_wdata),
        .sram_we_n_o  (mux_we_n)
    );

    assign bus.SRAM_address       = mux_addr;
    assign bus.SRAM_write_data    = mux_wdata;
    assign bus.SRAM_we_n          = mux_we_n;
    assign bus.uart_rx_initialize = init_q;
    assign bus.uart_rx_enable     = enable_q;
    assign bus.m2_start           = m2_start_q;
    assign bus.m1_start           = m1_start_q;
    assign bus.vga_enable         = vga_enable_q;
    assign bus.sched_state        = state_q;
    assign bus.protocol_error     = error_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_decode_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_sram_decode_scheduler : scoreboarded bench for the decode-flow scheduler.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_sram_decode_scheduler;

    localparam logic [25:0] TB_TIMEOUT = 26'd100;
    localparam logic [2:0]  ST_DISP  = 3'd0;
    localparam logic [2:0]  ST_UART  = 3'd1;
    localparam logic [2:0]  ST_GUARD = 3'd2;
    localparam logic [2:0]  ST_M2    = 3'd3;
    localparam logic [2:0]  ST_M1    = 3'd4;

    bit         Clock = 1'b0;
    logic       Resetn;
    int         n_checks = 0;
    int         n_errors = 0;
    logic [2:0] exp_q[$];
    logic [2:0] prev_state = 3'd0;
    int         m2_start_seen = 0;
    int         u;
    int         n;

    sram_decode_scheduler_if #(.ADDR_W(18)) bus ();

    sram_decode_scheduler #(
        .UART_TIMEOUT (TB_TIMEOUT),
        .GUARD_CYCLES (3),
        .ADDR_W       (18)
    ) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus)
    );

    always #5 Clock = ~Clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.uart_rx_line         = 1'b1;
        bus.skip_m2              = 1'b0;
        bus.uart_sram_address    = 18'h15555;
        bus.uart_sram_write_data = 16'hA5A5;
        bus.uart_sram_we_n       = 1'b1;
        bus.m2_done              = 1'b0;
        bus.m2_sram_address      = 18'h2AAAA;
        bus.m2_sram_write_data   = 16'h5A5A;
        bus.m2_sram_we_n         = 1'b1;
        bus.m1_done              = 1'b0;
        bus.m1_sram_address      = 18'h3C3C3;
        bus.m1_sram_write_data   = 16'h0FF0;
        bus.m1_sram_we_n         = 1'b1;
        bus.vga_sram_address     = 18'h01234;
    endtask

    task automatic do_reset();
        Resetn = 1'b0;
        #1;
        check_val("rst_state",    32'(bus.sched_state),        32'(ST_DISP));
        check_val("rst_we_n",     32'(bus.SRAM_we_n),          32'd1);
        check_val("rst_addr",     32'(bus.SRAM_address),       32'h01234);
        check_val("rst_wdata",    32'(bus.SRAM_write_data),    32'd0);
        check_val("rst_vga_en",   32'(bus.vga_enable),         32'd1);
        check_val("rst_error",    32'(bus.protocol_error),     32'd0);
        check_val("rst_init",     32'(bus.uart_rx_initialize), 32'd0);
        check_val("rst_m2_start", 32'(bus.m2_start),           32'd0);
        idle_inputs();
        step();
        Resetn = 1'b1;
    endtask

    task automatic start_load(input bit skip);
        bus.skip_m2 = skip;
        exp_q.push_back(ST_UART);
        exp_q.push_back(ST_GUARD);
        exp_q.push_back(skip ? ST_M1 : ST_M2);
        bus.uart_rx_line = 1'b0;
        step();
        bus.uart_rx_line = 1'b1;
    endtask

    task automatic wait_state(input string tag, input logic [2:0] st, input int max_cyc, output int cnt);
        cnt = 0;
        while (bus.sched_state != st && cnt < max_cyc) begin
            step();
            cnt++;
        end
        check_val(tag, 32'(bus.sched_state), 32'(st));
    endtask

    // State scoreboard: every observed transition must match the next expected entry.
    always @(negedge Clock) begin
        if (!Resetn) begin
            prev_state = ST_DISP;
        end else begin
            if (bus.m2_start) m2_start_seen++;
            if (bus.sched_state != prev_state) begin
                if (exp_q.size() == 0)
                    check_val("sb_unexpected", 32'(bus.sched_state), 32'(prev_state));
                else
                    check_val("sb_state", 32'(bus.sched_state), 32'(exp_q.pop_front()));
                prev_state = bus.sched_state;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        Resetn = 1'b1;
        #2;
        do_reset();
        step();
        step();
        check_val("idle_display", 32'(bus.sched_state), 32'(ST_DISP));

        // Load flow with writes at UART cycles 10 and 50
        start_load(1'b0);
        u = 1;
        check_val("init_c1",    32'(bus.uart_rx_initialize), 32'd1);
        check_val("enable_c1",  32'(bus.uart_rx_enable),     32'd0);
        check_val("vga_off",    32'(bus.vga_enable),         32'd0);
        step();
        u = 2;
        check_val("init_c2",    32'(bus.uart_rx_initialize), 32'd0);
        check_val("enable_c2",  32'(bus.uart_rx_enable),     32'd1);
        while (bus.sched_state == ST_UART && u < 400) begin
            step();
            u++;
            bus.uart_sram_we_n = !(u == 10 || u == 50);
            if (u == 3) check_val("enable_c3", 32'(bus.uart_rx_enable), 32'd0);
            if (u == 10) begin
                #1;
                check_val("uart_we_n",  32'(bus.SRAM_we_n),       32'd0);
                check_val("uart_addr",  32'(bus.SRAM_address),    32'h15555);
                check_val("uart_wdata", 32'(bus.SRAM_write_data), 32'hA5A5);
            end
        end
        bus.uart_sram_we_n = 1'b1;
        check_val("guard_entry_cycle", 32'(u), 32'(50 + 100 + 2));

        // Guard window then M2 start
        for (int g = 0; g < 3; g++) begin
            check_val("guard_state", 32'(bus.sched_state),     32'(ST_GUARD));
            check_val("guard_we_n",  32'(bus.SRAM_we_n),       32'd1);
            check_val("guard_addr",  32'(bus.SRAM_address),    32'd0);
            check_val("guard_wdata", 32'(bus.SRAM_write_data), 32'd0);
            step();
        end
        check_val("m2_state",     32'(bus.sched_state),  32'(ST_M2));
        check_val("m2_start_hi",  32'(bus.m2_start),     32'd1);
        check_val("m2_addr",      32'(bus.SRAM_address), 32'h2AAAA);
        step();
        check_val("m2_start_lo",  32'(bus.m2_start),     32'd0);

        // Full chain M2 -> M1 -> DISPLAY
        exp_q.push_back(ST_GUARD);
        exp_q.push_back(ST_M1);
        bus.m2_sram_we_n = 1'b0;
        bus.m2_done      = 1'b1;
        #1;
        check_val("m2_we_n", 32'(bus.SRAM_we_n), 32'd0);
        step();
        bus.m2_done      = 1'b0;
        bus.m2_sram_we_n = 1'b1;
        check_val("m2_to_guard", 32'(bus.sched_state), 32'(ST_GUARD));
        wait_state("to_m1", ST_M1, 10, n);
        check_val("m1_guard_len", 32'(n), 32'd3);
        check_val("m1_start_hi",  32'(bus.m1_start),   32'd1);
        check_val("m1_vga_off",   32'(bus.vga_enable), 32'd0);
        exp_q.push_back(ST_GUARD);
        exp_q.push_back(ST_DISP);
        bus.m1_done = 1'b1;
        step();
        bus.m1_done = 1'b0;
        wait_state("to_disp", ST_DISP, 10, n);
        check_val("disp_vga_on",  32'(bus.vga_enable),     32'd1);
        check_val("disp_addr",    32'(bus.SRAM_address),   32'h01234);
        check_val("chain_no_err", 32'(bus.protocol_error), 32'd0);
        step();
        check_val("drain_chain",  32'(exp_q.size()),       32'd0);

        // skip_m2 flow with non-owner M2 write during M1
        do_reset();
        m2_start_seen = 0;
        step();
        start_load(1'b1);
        wait_state("skip_to_guard", ST_GUARD, 200, n);
        check_val("skip_timeout_len", 32'(n), 32'(101));
        wait_state("skip_to_m1", ST_M1, 10, n);
        check_val("skip_m1_start", 32'(bus.m1_start), 32'd1);
        bus.m1_sram_we_n = 1'b0;
        bus.m2_sram_we_n = 1'b0;
        #1;
        check_val("m1_we_n_lo", 32'(bus.SRAM_we_n),    32'd0);
        check_val("m1_addr",    32'(bus.SRAM_address), 32'h3C3C3);
        step();
        check_val("m2_we_err",  32'(bus.protocol_error), 32'd1);
        check_val("m2_we_stay", 32'(bus.sched_state),    32'(ST_M1));
        bus.m1_sram_we_n = 1'b1;
        #1;
        check_val("m1_we_n_hi", 32'(bus.SRAM_we_n), 32'd1);
        bus.m2_sram_we_n = 1'b1;
        exp_q.push_back(ST_GUARD);
        exp_q.push_back(ST_DISP);
        bus.m1_done = 1'b1;
        step();
        bus.m1_done = 1'b0;
        wait_state("skip_to_disp", ST_DISP, 10, n);
        step();
        check_val("skip_no_m2_start", 32'(m2_start_seen), 32'd0);
        check_val("err_sticky",       32'(bus.protocol_error), 32'd1);
        check_val("drain_skip",       32'(exp_q.size()), 32'd0);

        // Misdirected m1_done in M2, then reset mid-operation
        do_reset();
        step();
        start_load(1'b0);
        wait_state("e_to_m2", ST_M2, 200, n);
        step();
        bus.m1_done = 1'b1;
        step();
        bus.m1_done = 1'b0;
        check_val("m1_done_err",  32'(bus.protocol_error), 32'd1);
        check_val("m1_done_stay", 32'(bus.sched_state),    32'(ST_M2));
        bus.m2_sram_we_n = 1'b0;
        #1;
        check_val("e_m2_we_n",  32'(bus.SRAM_we_n), 32'd0);
        step();
        check_val("drain_err",  32'(exp_q.size()), 32'd0);
        do_reset();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_decode_scheduler.md
Name: sram_decode_scheduler

Overview:
- Top-level sequencer for the image decoder flow: UART load, then M2 (IDCT), then M1 (CSC/interpolation), then VGA display.
- Sole owner of the single SRAM controller port. It muxes the address, write data and we_n from whichever unit currently owns the bus.
- Inserts a drain guard at every ownership change so in-flight reads complete before the next owner drives the bus.
- Replaces the ad-hoc top_state and assign-muxing in the top module.

Parameters:
- UART_TIMEOUT, 26'd49999999, idle cycles (1 s at 50 MHz) with no UART SRAM write before the load is declared finished.
- GUARD_CYCLES, 3, cycles with we_n forced high between owners (SRAM read latency 2, plus 1).
- ADDR_W, 18, SRAM address width.

Ports:
- Clock  in  1  50 MHz system clock.
- Resetn  in  1  asynchronous, active-low reset.
- uart_rx_line  in  1  raw UART RX level; low = start bit.
- skip_m2  in  1  when high, the flow goes UART -> M1 directly.
- uart_sram_address  in  18  UART unit address.
- uart_sram_write_data  in  16  UART unit write data.
- uart_sram_we_n  in  1  UART unit write enable.
- uart_rx_initialize  out  1  one-cycle init pulse to the UART unit.
- uart_rx_enable  out  1  one-cycle enable pulse to the UART unit.
- m2_start  out  1  one-cycle start pulse to M2.
- m2_done  in  1  done pulse from M2.
- m2_sram_address  in  18  M2 address.
- m2_sram_write_data  in  16  M2 write data.
- m2_sram_we_n  in  1  M2 write enable.
- m1_start  out  1  one-cycle start pulse to M1.
- m1_done  in  1  done pulse from M1.
- m1_sram_address  in  18  M1 address.
- m1_sram_write_data  in  16  M1 write data.
- m1_sram_we_n  in  1  M1 write enable.
- vga_sram_address  in  18  VGA unit address.
- vga_enable  out  1  enables the VGA SRAM interface.
- SRAM_address  out  18  to SRAM controller.
- SRAM_write_data  out  16  to SRAM controller.
- SRAM_we_n  out  1  to SRAM controller.
- sched_state  out  3  current state code (for LEDs and the bench).
- protocol_error  out  1  sticky error flag.

Behaviour:
- Reset values:
  - State S_SCH_DISPLAY; vga_enable=1.
  - uart_rx_initialize, uart_rx_enable, m1_start, m2_start = 0.
  - Timer = 0, guard counter = 0, protocol_error = 0.
  - SRAM_we_n=1, SRAM_write_data=0, SRAM_address=vga_sram_address.
- SRAM mux: combinational from the registered state, zero added latency.
  - DISPLAY selects VGA address, write data 0, we_n 1.
  - UART, M2 and M1 each select their own unit's three signals.
  - GUARD drives address 0, write data 0, we_n 1.
- S_SCH_DISPLAY: if uart_rx_line==0, go to S_SCH_UART next cycle. In the same edge:
  - uart_rx_initialize<=1, vga_enable<=0, timer<=0.
- S_SCH_UART:
  - uart_rx_initialize is high for exactly one cycle. uart_rx_enable pulses for the single cycle after that.
  - Timer increments every cycle and clears to 0 in any cycle where uart_sram_we_n==0.
  - When timer==UART_TIMEOUT: go to GUARD, with next = skip_m2 ? M1 : M2. skip_m2 is sampled at that edge.
- S_SCH_GUARD:
  - The counter loads GUARD_CYCLES-1 on entry and decrements each cycle.
  - At 0 the scheduler enters the next state, and the matching start pulse (m2_start or m1_start) is high for the first cycle in that state.
  - For next = DISPLAY, vga_enable<=1 on entry.
- S_SCH_M2: m2_done -> GUARD with next = M1.
- S_SCH_M1: m1_done -> GUARD with next = DISPLAY.
- Ignored events:
  - A start bit during UART, GUARD, M2 or M1 is ignored. Only DISPLAY accepts a new load.
  - A done pulse in the cycle its own start is high is accepted as a zero-length run.
- protocol_error is set (sticky until reset) when:
  - a non-owner among UART/M1/M2 drives we_n=0; or
  - m1_done or m2_done arrives while its unit is not the owner.
  - The offending done pulse is otherwise ignored.
  - If m1_done and m2_done arrive together in M2: m2_done acts and the error sets.
- Reset mid-operation returns to DISPLAY immediately (async). SRAM_we_n goes high combinationally.
- sched_state codes: DISPLAY=0, UART=1, GUARD=2, M2=3, M1=4.

Decomposition:
- sched_pkg holds:
  - typedef enum logic [2:0] sched_state_type with the codes above;
  - owner select typedef;
  - UART_TIMEOUT and GUARD_CYCLES defaults.
- Sub-module sram_owner_mux: purely combinational 4-way select plus forced-idle guard output. The FSM, timer and error logic stay in the top.

Test Plan:
- Reset with vga_sram_address=18'h1234 -> SRAM_address=18'h1234, SRAM_we_n=1, vga_enable=1, sched_state=0.
- Load flow:
  - Stimulus: uart_rx_line low 1 cycle, UART_TIMEOUT overridden to 100, uart_sram_we_n pulsed at cycles 10 and 50.
  - Required: init pulse at cycle 1, enable pulse at cycle 2, GUARD entered exactly 100 cycles after the last write.
- Guard and start:
  - Stimulus: enter M2 from UART.
  - Required: exactly 3 GUARD cycles with SRAM_we_n=1 and address 0, then m2_start high 1 cycle with SRAM_address=m2_sram_address.
- Full chain, skip_m2=0:
  - Stimulus: m2_done, then m1_done.
  - Required: states 1->2->3->2->4->2->0, and vga_enable returns to 1 on DISPLAY entry.
- skip_m2=1 -> UART->GUARD->M1. m2_start is never asserted.
- Error cases:
  - m1_done during M2 -> protocol_error=1, state stays M2.
  - m2_sram_we_n=0 during M1 -> protocol_error=1, and SRAM_we_n still follows m1_sram_we_n.
